// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-aware arbiter driving the single push port of a FIFO.
// A grant is held from the first beat of a burst until its last beat transfers.
module fifo_push_arbiter #(
    parameter int width                         = 8,
    parameter int n_requesters                  = 4,
    parameter bit allow_push_when_full_with_pop = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [n_requesters-1:0]         req_valid,
    input  logic [n_requesters-1:0]         req_last,
    input  logic [n_requesters*width-1:0]   req_data,
    output logic [n_requesters-1:0]         req_ready,
    input  logic                            fifo_full,
    input  logic                            fifo_pop,
    output logic                            fifo_push,
    output logic [width-1:0]                fifo_write_data,
    output logic                            grant_valid,
    output logic [$clog2(n_requesters)-1:0] grant_id,
    output logic                            locked
);

    localparam int id_w = $clog2(n_requesters);
    localparam logic [id_w-1:0] last_id = id_w'(n_requesters - 1);

    logic [id_w-1:0] rr_ptr;
    logic [id_w-1:0] lock_id;
    logic [id_w-1:0] rr_id;
    logic            any_valid;
    logic            can_push;

    assign any_valid = |req_valid;
    assign can_push  = ~fifo_full | (allow_push_when_full_with_pop & fifo_pop);

    // First valid requester scanning upward from rr_ptr with wrap-around.
    always_comb begin
        logic found;
        logic [id_w-1:0] idx;
        rr_id = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < n_requesters; k++) begin
            idx = id_w'((32'(rr_ptr) + k) % n_requesters);
            if (!found && req_valid[idx]) begin
                rr_id = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_valid     = locked | any_valid;
        grant_id        = locked ? lock_id : (any_valid ? rr_id : '0);
        fifo_push       = grant_valid & req_valid[grant_id] & can_push;
        fifo_write_data = '0;
        req_ready       = '0;
        for (int unsigned i = 0; i < n_requesters; i++) begin
            if (grant_valid && grant_id == id_w'(i))
                fifo_write_data = req_data[i*width +: width];
            req_ready[i] = fifo_push && (grant_id == id_w'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (fifo_push) begin
            if (req_last[grant_id]) begin
                locked <= 1'b0;
                rr_ptr <= (grant_id == last_id) ? '0 : grant_id + 1'b1;
            end else begin
                locked  <= 1'b1;
                lock_id <= grant_id;
            end
        end
    end

endmodule
